// File: rtl/ram_sp_256x32_arb.sv
//------------------------------------------------------------------------------
// Module      : ram_sp_256x32_arb
// Description : Round-robin two-client arbiter and sequencer in front of one
//               256x32 single-port synchronous SRAM (1-cycle read latency).
//               Read data is returned to the client that issued the read.
//               Optional feature macro RAM_ARB_INIT_EN: zero-fill the whole
//               array after reset before any client is served.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module ram_sp_256x32_arb (
  input  logic        clk,
  input  logic        rst,
  input  logic        c0_req_i,
  input  logic        c0_we_i,
  input  logic [7:0]  c0_adr_i,
  input  logic [31:0] c0_dat_i,
  output logic        c0_gnt_o,
  output logic        c0_vld_o,
  input  logic        c1_req_i,
  input  logic        c1_we_i,
  input  logic [7:0]  c1_adr_i,
  input  logic [31:0] c1_dat_i,
  output logic        c1_gnt_o,
  output logic        c1_vld_o,
  output logic [31:0] rd_dat_o,
  output logic        init_done_o,
  output logic [7:0]  ram_adr_o,
  output logic        ram_wr_ena_o,
  output logic [31:0] ram_wr_dat_o,
  output logic        ram_rd_ena_o,
  input  logic [31:0] ram_rd_dat_i
);

  logic w_run;       // arbiter may grant this cycle (ignoring rst)
  logic w_init_wr;   // zero-fill write active this cycle
  logic [7:0] w_init_adr;

`ifdef RAM_ARB_INIT_EN
  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0] state_q, state_d;
  logic [7:0] cnt_q, cnt_d;

  // Walk the counter through every address once, then hand over to RUN
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == ST_INIT) begin
      cnt_d = cnt_q + 8'd1;
      if (cnt_q == 8'hFF) begin
        state_d = ST_RUN;
      end
    end
  end

  // Sequencer state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_INIT;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign w_run       = (state_q == ST_RUN);
  assign w_init_wr   = (state_q == ST_INIT) && !rst;
  assign w_init_adr  = cnt_q;
  assign init_done_o = w_run;
`else
  assign w_run       = 1'b1;
  assign w_init_wr   = 1'b0;
  assign w_init_adr  = 8'd0;
  assign init_done_o = 1'b1;
`endif

  logic lst_q, lst_d;          // last granted client (1 = client 1)
  logic tag_vld_q, tag_vld_d;  // a read was granted last cycle
  logic tag_own_q, tag_own_d;  // owner of that read
  logic w_gnt0, w_gnt1, w_any, w_we;

  // Round-robin grant; on a tie the client that did not win last time wins.
  // No grants while rst is high so the reset cycle never issues an access.
  always_comb begin
    w_gnt0 = w_run && !rst && c0_req_i && (!c1_req_i || lst_q);
    w_gnt1 = w_run && !rst && c1_req_i && (!c0_req_i || !lst_q);
    w_any  = w_gnt0 || w_gnt1;
    w_we   = w_gnt1 ? c1_we_i : c0_we_i;
    lst_d  = w_gnt1 ? 1'b1 : (w_gnt0 ? 1'b0 : lst_q);
    tag_vld_d = w_any && !w_we;
    tag_own_d = w_gnt1;
  end

  // Pointer and read-return tag registers
  always_ff @(posedge clk) begin
    if (rst) begin
      lst_q     <= 1'b1;
      tag_vld_q <= 1'b0;
      tag_own_q <= 1'b0;
    end else begin
      lst_q     <= lst_d;
      tag_vld_q <= tag_vld_d;
      tag_own_q <= tag_own_d;
    end
  end

  // SRAM command mux: zero-fill writes take priority, otherwise the granted
  // client drives the bus; with no grant client 0 inputs keep it stable.
  always_comb begin
    ram_adr_o    = w_gnt1 ? c1_adr_i : c0_adr_i;
    ram_wr_dat_o = w_gnt1 ? c1_dat_i : c0_dat_i;
    ram_wr_ena_o = w_any && w_we;
    ram_rd_ena_o = w_any && !w_we;
    if (w_init_wr) begin
      ram_adr_o    = w_init_adr;
      ram_wr_dat_o = 32'd0;
      ram_wr_ena_o = 1'b1;
      ram_rd_ena_o = 1'b0;
    end
  end

  assign c0_gnt_o = w_gnt0;
  assign c1_gnt_o = w_gnt1;
  assign c0_vld_o = tag_vld_q && !tag_own_q;
  assign c1_vld_o = tag_vld_q && tag_own_q;
  assign rd_dat_o = ram_rd_dat_i;

endmodule

`default_nettype wire

// File: tb/tb_ram_sp_256x32_arb.sv
//------------------------------------------------------------------------------
// Module      : tb_ram_sp_256x32_arb
// Description : Directed self-checking bench for ram_sp_256x32_arb with a
//               behavioural 256x32 single-port SRAM attached.
//               Follows RAM_ARB_INIT_EN when defined.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_ram_sp_256x32_arb;

  logic        clk;
  logic        rst;
  logic        c0_req, c0_we, c1_req, c1_we;
  logic [7:0]  c0_adr, c1_adr;
  logic [31:0] c0_dat, c1_dat;
  logic        c0_gnt, c0_vld, c1_gnt, c1_vld;
  logic [31:0] rd_dat;
  logic        init_done;
  logic [7:0]  ram_adr;
  logic        ram_wr_ena, ram_rd_ena;
  logic [31:0] ram_wr_dat;
  logic [31:0] ram_rd_dat;

  logic [31:0] mem [0:255];

  int n_tests = 0;
  int n_fail  = 0;

  ram_sp_256x32_arb dut (
    .clk          (clk),
    .rst          (rst),
    .c0_req_i     (c0_req),
    .c0_we_i      (c0_we),
    .c0_adr_i     (c0_adr),
    .c0_dat_i     (c0_dat),
    .c0_gnt_o     (c0_gnt),
    .c0_vld_o     (c0_vld),
    .c1_req_i     (c1_req),
    .c1_we_i      (c1_we),
    .c1_adr_i     (c1_adr),
    .c1_dat_i     (c1_dat),
    .c1_gnt_o     (c1_gnt),
    .c1_vld_o     (c1_vld),
    .rd_dat_o     (rd_dat),
    .init_done_o  (init_done),
    .ram_adr_o    (ram_adr),
    .ram_wr_ena_o (ram_wr_ena),
    .ram_wr_dat_o (ram_wr_dat),
    .ram_rd_ena_o (ram_rd_ena),
    .ram_rd_dat_i (ram_rd_dat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural single-port SRAM, 1-cycle read latency
  always @(posedge clk) begin
    if (ram_wr_ena) mem[ram_adr] <= ram_wr_dat;
    if (ram_rd_ena) ram_rd_dat <= mem[ram_adr];
  end

  // Preloaded content seen before any write (no zero-fill build)
  function automatic logic [31:0] pre(input logic [7:0] a);
`ifdef RAM_ARB_INIT_EN
    pre = 32'd0;
`else
    pre = 32'hC0DE_0000 | {24'd0, a};
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        e, prev;
    logic [7:0]  radr [0:2];
    logic [31:0] rexp [0:2];
    logic [31:0] prevd;
    int          n;

    for (int i = 0; i < 256; i++) mem[i] = 32'hC0DE_0000 | i;
    ram_rd_dat = 32'd0;
    rst = 1'b1;
    c0_req = 1'b1; c0_we = 1'b0; c0_adr = 8'h10; c0_dat = 32'd0;
    c1_req = 1'b0; c1_we = 1'b0; c1_adr = 8'h00; c1_dat = 32'd0;
    repeat (3) cyc();

    // Reset state with a pending request
    @(negedge clk);
    chk("rst_gnt0",   32'(c0_gnt),     32'd0);
    chk("rst_vld0",   32'(c0_vld),     32'd0);
    chk("rst_wr_ena", 32'(ram_wr_ena), 32'd0);
    chk("rst_rd_ena", 32'(ram_rd_ena), 32'd0);
`ifdef RAM_ARB_INIT_EN
    chk("rst_init_done", 32'(init_done), 32'd0);
`else
    chk("rst_init_done", 32'(init_done), 32'd1);
`endif
    cyc();
    rst = 1'b0;

`ifdef RAM_ARB_INIT_EN
    // Zero-fill sweep, request held off
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      chk("init_wr_ena", 32'(ram_wr_ena), 32'd1);
      chk("init_adr",    32'(ram_adr),    32'(i));
      chk("init_wdat",   ram_wr_dat,      32'd0);
      chk("init_gnt0",   32'(c0_gnt),     32'd0);
      chk("init_done0",  32'(init_done),  32'd0);
      cyc();
    end
`endif

    // First grant right after reset / zero-fill
    @(negedge clk);
    chk("first_gnt0",   32'(c0_gnt),     32'd1);
    chk("first_done",   32'(init_done),  32'd1);
    chk("first_rd_ena", 32'(ram_rd_ena), 32'd1);
    chk("first_adr",    32'(ram_adr),    32'h10);
    cyc();
    c0_req = 1'b0;
    @(negedge clk);
    chk("first_vld0", 32'(c0_vld), 32'd1);
    chk("first_vld1", 32'(c1_vld), 32'd0);
    chk("first_data", rd_dat,      pre(8'h10));

    // Write then read-back from the same address
    cyc();
    c0_req = 1'b1; c0_we = 1'b1; c0_adr = 8'h3A; c0_dat = 32'hDEADBEEF;
    @(negedge clk);
    chk("wr_gnt0",   32'(c0_gnt),     32'd1);
    chk("wr_wr_ena", 32'(ram_wr_ena), 32'd1);
    chk("wr_rd_ena", 32'(ram_rd_ena), 32'd0);
    chk("wr_adr",    32'(ram_adr),    32'h3A);
    chk("wr_wdat",   ram_wr_dat,      32'hDEADBEEF);
    cyc();
    c0_we = 1'b0;
    @(negedge clk);
    chk("rb_gnt0",   32'(c0_gnt),     32'd1);
    chk("rb_rd_ena", 32'(ram_rd_ena), 32'd1);
    chk("rb_vld0_early", 32'(c0_vld), 32'd0);
    cyc();
    c0_req = 1'b0;
    @(negedge clk);
    chk("rb_vld0", 32'(c0_vld), 32'd1);
    chk("rb_vld1", 32'(c1_vld), 32'd0);
    chk("rb_data", rd_dat,      32'hDEADBEEF);
    chk("idle_rd_ena", 32'(ram_rd_ena), 32'd0);
    chk("idle_wr_ena", 32'(ram_wr_ena), 32'd0);

    // Load contention data: c0 writes 0x01, then c1 writes 0x02
    cyc();
    c0_req = 1'b1; c0_we = 1'b1; c0_adr = 8'h01; c0_dat = 32'h11111111;
    @(negedge clk);
    chk("ld0_gnt0", 32'(c0_gnt), 32'd1);
    cyc();
    c0_req = 1'b0;
    c1_req = 1'b1; c1_we = 1'b1; c1_adr = 8'h02; c1_dat = 32'h22222222;
    @(negedge clk);
    chk("ld1_gnt1", 32'(c1_gnt),  32'd1);
    chk("ld1_gnt0", 32'(c0_gnt),  32'd0);
    chk("ld1_adr",  32'(ram_adr), 32'h02);
    chk("ld1_wdat", ram_wr_dat,   32'h22222222);

    // Continuous contention: last grant was client 1, so 0,1,0,1,...
    cyc();
    c0_req = 1'b1; c0_we = 1'b0; c0_adr = 8'h01;
    c1_req = 1'b1; c1_we = 1'b0; c1_adr = 8'h02;
    prev = 1'b0;
    for (int i = 0; i < 6; i++) begin
      e = i[0];
      @(negedge clk);
      chk("rr_gnt0", 32'(c0_gnt),  32'(!e));
      chk("rr_gnt1", 32'(c1_gnt),  32'(e));
      chk("rr_adr",  32'(ram_adr), e ? 32'h02 : 32'h01);
      if (i > 0) begin
        chk("rr_vld0", 32'(c0_vld), 32'(!prev));
        chk("rr_vld1", 32'(c1_vld), 32'(prev));
        chk("rr_data", rd_dat,      prev ? 32'h22222222 : 32'h11111111);
      end
      prev = e;
      cyc();
    end

    // Client 1 alone: three back-to-back reads
    c0_req = 1'b0;
    radr[0] = 8'h02; rexp[0] = 32'h22222222;
    radr[1] = 8'h01; rexp[1] = 32'h11111111;
    radr[2] = 8'h3A; rexp[2] = 32'hDEADBEEF;
    prevd = 32'h22222222;
    for (int j = 0; j < 3; j++) begin
      c1_adr = radr[j];
      @(negedge clk);
      chk("c1b_gnt1", 32'(c1_gnt), 32'd1);
      chk("c1b_gnt0", 32'(c0_gnt), 32'd0);
      chk("c1b_vld1", 32'(c1_vld), 32'd1);
      chk("c1b_vld0", 32'(c0_vld), 32'd0);
      chk("c1b_data", rd_dat,      prevd);
      prevd = rexp[j];
      cyc();
    end

    // Tie after client 1 streak goes to client 0
    c0_req = 1'b1; c0_we = 1'b0; c0_adr = 8'h3A;
    c1_adr = 8'h02;
    @(negedge clk);
    chk("tie_gnt0", 32'(c0_gnt), 32'd1);
    chk("tie_gnt1", 32'(c1_gnt), 32'd0);
    chk("tie_vld1", 32'(c1_vld), 32'd1);
    chk("tie_data", rd_dat,      32'hDEADBEEF);
    cyc();
    c0_req = 1'b0; c1_req = 1'b0;
    @(negedge clk);
    chk("tie_vld0_ret", 32'(c0_vld), 32'd1);
    chk("tie_vld1_ret", 32'(c1_vld), 32'd0);
    chk("tie_data_ret", rd_dat,      32'hDEADBEEF);

    // Read request during a reset cycle yields no access and no vld
    cyc();
    rst = 1'b1;
    c0_req = 1'b1; c0_we = 1'b0; c0_adr = 8'h01;
    @(negedge clk);
    chk("rstrd_gnt0",   32'(c0_gnt),     32'd0);
    chk("rstrd_rd_ena", 32'(ram_rd_ena), 32'd0);
    cyc();
    rst = 1'b0; c0_req = 1'b0;
    @(negedge clk);
    chk("rstrd_vld0", 32'(c0_vld), 32'd0);
    chk("rstrd_vld1", 32'(c1_vld), 32'd0);

`ifdef RAM_ARB_INIT_EN
    // Interrupt zero-fill at cycle 100
    chk("mid_adr0", 32'(ram_adr), 32'd0);
    repeat (100) cyc();
`else
    cyc();
`endif
    rst = 1'b1;
    c0_req = 1'b1; c0_we = 1'b0; c0_adr = 8'h3A;
    cyc();
    rst = 1'b0;
    @(negedge clk);
`ifdef RAM_ARB_INIT_EN
    chk("restart_adr",    32'(ram_adr),    32'd0);
    chk("restart_wr_ena", 32'(ram_wr_ena), 32'd1);
`endif
    n = 0;
    while (!c0_gnt && n < 400) begin
      cyc();
      n++;
      @(negedge clk);
    end
`ifdef RAM_ARB_INIT_EN
    chk("restart_cycles", 32'(n), 32'd256);
`else
    chk("restart_cycles", 32'(n), 32'd0);
`endif
    chk("restart_gnt0", 32'(c0_gnt),    32'd1);
    chk("restart_done", 32'(init_done), 32'd1);
    cyc();
    c0_req = 1'b0;
    @(negedge clk);
    chk("restart_vld0", 32'(c0_vld), 32'd1);
`ifdef RAM_ARB_INIT_EN
    chk("restart_data", rd_dat, 32'd0);
`else
    chk("restart_data", rd_dat, 32'hDEADBEEF);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
